// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the parametrised PISO serializer: state encodings and counter sizing.
package piso_serializer_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    // Down-counter width able to hold WIDTH-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Producer-facing handshake plus serial output bundle of the PISO serializer.
interface piso_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             msb_first;
    logic             out;
    logic             out_valid;
    logic             last;

    modport master (
        output in_data, in_valid, msb_first,
        input  in_ready, out, out_valid, last
    );

    modport slave (
        input  in_data, in_valid, msb_first,
        output in_ready, out, out_valid, last
    );
endinterface

// File: rtl/piso_serializer_bit_counter.sv
// Loadable down-counter with zero flag; holds the bits-remaining count of the frame in flight.
module bit_counter
    import piso_serializer_pkg::*;
#(
    parameter int N  = 8,
    parameter int CW = cnt_width(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          dec,
    output logic [CW-1:0] cnt,
    output logic          zero
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out shifter: accepts a WIDTH-bit word on valid/ready and emits one bit
// per clock, MSB- or LSB-first per word, with back-to-back words streaming without a gap.
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int   WIDTH      = 8,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input logic                clk,
    input logic                rst,
    piso_serializer_if.slave   bus
);

    localparam int             CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LOAD_VAL = CW'(WIDTH - 1);

    generate
        if (WIDTH < 2) begin : g_width_chk
            $error("piso_serializer: WIDTH must be >= 2");
        end
    endgenerate

    logic [0:0]       state;
    logic [WIDTH-1:0] shreg;
    logic             mode;
    logic             out_q;
    logic [CW-1:0]    cnt;
    logic             cnt_zero;

    logic             shifting;
    logic             ready;
    logic             accept;
    logic             first_bit;
    logic             next_bit;

    assign shifting = (state == ST_SHIFT);
    // Ready again on the final bit so the next word follows it with no idle cycle.
    assign ready    = !shifting || cnt_zero;
    assign accept   = bus.in_valid && ready;

    assign first_bit = bus.msb_first ? bus.in_data[WIDTH-1] : bus.in_data[0];
    // Bit 0 of the frame is already on out when shreg is loaded, so the next bit
    // sits one position in from the output end.
    assign next_bit  = mode ? shreg[WIDTH-2] : shreg[1];

    bit_counter #(
        .N  (WIDTH),
        .CW (CW)
    ) u_bit_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_val (LOAD_VAL),
        .dec      (shifting),
        .cnt      (cnt),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            shreg <= '0;
            mode  <= 1'b0;
            out_q <= IDLE_LEVEL;
        end else if (accept) begin
            state <= ST_SHIFT;
            shreg <= bus.in_data;
            mode  <= bus.msb_first;
            out_q <= first_bit;
        end else if (shifting) begin
            if (cnt_zero) begin
                state <= ST_IDLE;
                out_q <= IDLE_LEVEL;
            end else begin
                shreg <= mode ? (shreg << 1) : (shreg >> 1);
                out_q <= next_bit;
            end
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out       = out_q;
    assign bus.out_valid = shifting;
    assign bus.last      = shifting && cnt_zero;

endmodule
